// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes and glitch-filters an asynchronous PWM pin and
// reports period and high time (in clk cycles) once per completed period.
module pwm_capture #(
    parameter int CNT_W = 16,
    parameter int FILT  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam int              FC_W      = 4;
    localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } state_t;

    logic [1:0]      sync_reg;
    logic            sync_s;
    logic [FC_W-1:0] fcnt_reg;
    logic            lvl_reg;
    logic            lvl_d_reg;
    logic            rise;
    logic            fall;
    logic            timeout;

    state_t          state_reg;
    state_t          state_next;

    logic [CNT_W-1:0] pcnt_reg, pcnt_next;
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic [CNT_W-1:0] high_reg, high_next;
    logic             valid_reg, valid_next;
    logic             stuck_reg, stuck_next;
    logic             stuck_level_reg, stuck_level_next;

    assign sync_s = sync_reg[1];

    // Synchronizer plus filter: lvl flips only after FILT consecutive
    // synchronized samples disagree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= 2'b00;
            fcnt_reg  <= '0;
            lvl_reg   <= 1'b0;
            lvl_d_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], pwm_in};
            lvl_d_reg <= lvl_reg;
            if (sync_s != lvl_reg) begin
                if (fcnt_reg == FILT_LAST) begin
                    lvl_reg  <= sync_s;
                    fcnt_reg <= '0;
                end else begin
                    fcnt_reg <= fcnt_reg + FC_W'(1);
                end
            end else begin
                fcnt_reg <= '0;
            end
        end
    end

    assign rise = lvl_reg & ~lvl_d_reg;
    assign fall = ~lvl_reg & lvl_d_reg;

    // A closing rise on the saturation cycle wins over the timeout.
    assign timeout = (state_reg != WAIT_RISE) && (pcnt_reg == CNT_MAX) && !rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WAIT_RISE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!en) begin
            state_next = WAIT_RISE;
        end else begin
            case (state_reg)
                WAIT_RISE: if (rise) state_next = HIGH;
                HIGH: begin
                    if (timeout)   state_next = WAIT_RISE;
                    else if (fall) state_next = LOW;
                end
                LOW: begin
                    if (rise)         state_next = HIGH;
                    else if (timeout) state_next = WAIT_RISE;
                end
                default: state_next = WAIT_RISE;
            endcase
        end
    end

    always_comb begin
        pcnt_next        = pcnt_reg;
        hcnt_next        = hcnt_reg;
        period_next      = period_reg;
        high_next        = high_reg;
        valid_next       = 1'b0;
        stuck_next       = stuck_reg;
        stuck_level_next = stuck_level_reg;
        if (!en) begin
            pcnt_next = '0;
            hcnt_next = '0;
        end else begin
            case (state_reg)
                WAIT_RISE: begin
                    if (rise) begin
                        pcnt_next = CNT_ONE;
                        hcnt_next = CNT_ONE;
                    end
                end
                HIGH: begin
                    if (timeout) begin
                        pcnt_next        = '0;
                        hcnt_next        = '0;
                        stuck_next       = 1'b1;
                        stuck_level_next = lvl_reg;
                    end else begin
                        pcnt_next = pcnt_reg + CNT_ONE;
                        if (!fall) hcnt_next = hcnt_reg + CNT_ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_next = pcnt_reg;
                        high_next   = hcnt_reg;
                        valid_next  = 1'b1;
                        stuck_next  = 1'b0;
                        pcnt_next   = CNT_ONE;
                        hcnt_next   = CNT_ONE;
                    end else if (timeout) begin
                        pcnt_next        = '0;
                        hcnt_next        = '0;
                        stuck_next       = 1'b1;
                        stuck_level_next = lvl_reg;
                    end else begin
                        pcnt_next = pcnt_reg + CNT_ONE;
                    end
                end
                default: begin
                    pcnt_next = '0;
                    hcnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg        <= '0;
            hcnt_reg        <= '0;
            period_reg      <= '0;
            high_reg        <= '0;
            valid_reg       <= 1'b0;
            stuck_reg       <= 1'b0;
            stuck_level_reg <= 1'b0;
        end else begin
            pcnt_reg        <= pcnt_next;
            hcnt_reg        <= hcnt_next;
            period_reg      <= period_next;
            high_reg        <= high_next;
            valid_reg       <= valid_next;
            stuck_reg       <= stuck_next;
            stuck_level_reg <= stuck_level_next;
        end
    end

    assign period      = period_reg;
    assign high_time   = high_reg;
    assign valid       = valid_reg;
    assign stuck       = stuck_reg;
    assign stuck_level = stuck_level_reg;

endmodule
